// File: rtl/aud_dac_serializer_if.sv
// rtl/aud_dac_serializer_if.sv - stereo sample stream into the DAC serializer
interface aud_dac_serializer_if #(
  parameter int SAMPLE_W = 24
) ();
  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_left;
  logic [SAMPLE_W-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/aud_dac_serializer.sv
// rtl/aud_dac_serializer.sv - codec clock generation and left-justified stereo DAC serializer
// Optional build macro UNDERRUN_MUTE_EN: underrun frames play silence instead of repeating.
module aud_dac_serializer #(
  parameter int SAMPLE_W  = 24,
  parameter int SLOT_W    = 32,
  parameter int MCLK_HALF = 2,
  parameter int BCLK_HALF = 4
) (
  input  logic                CLOCK_50_B5B,
  input  logic                CPU_RESET_n,
  aud_dac_serializer_if.slave s_if,
  output logic                AUD_XCK,
  output logic                AUD_BCLK,
  output logic                AUD_DACLRCK,
  output logic                AUD_DACDAT,
  output logic                frame_strobe,
  output logic [15:0]         underrun_cnt
);
  localparam int FRAME = 2 * SLOT_W;
  localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int MW    = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int BW    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int IDX_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

  generate
    if (SAMPLE_W < 1 || SAMPLE_W > SLOT_W || MCLK_HALF < 1 || BCLK_HALF < 1) begin : g_bad_params
      $error("aud_dac_serializer: illegal parameter combination");
    end
  endgenerate

  logic [MW-1:0]       r_xcnt;
  logic                r_xck;
  logic [BW-1:0]       r_bcnt;
  logic                r_bclk;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic                r_lrck;
  logic                r_dat;
  logic                r_strobe;
  logic [15:0]         r_underrun_cnt;
  logic                r_hold_full;
  logic [SAMPLE_W-1:0] r_hold_l, r_hold_r;
  logic [SAMPLE_W-1:0] r_last_l, r_last_r;
  logic [SAMPLE_W-1:0] r_sh_l, r_sh_r;

  logic                w_xwrap, w_bwrap, w_fall, w_load, w_accept;
  logic [CNT_W-1:0]    w_next_cnt, w_k;
  logic                w_next_lr;
  logic [SAMPLE_W-1:0] w_load_l, w_load_r, w_nxt_l, w_nxt_r, w_chan;
  logic [IDX_W-1:0]    w_idx;
  logic                w_bit;

  assign w_xwrap    = (r_xcnt == MW'(MCLK_HALF - 1));
  assign w_bwrap    = (r_bcnt == BW'(BCLK_HALF - 1));
  assign w_fall     = w_bwrap && r_bclk;
  assign w_load     = w_fall && (r_bit_cnt == CNT_W'(FRAME - 1));
  assign s_if.s_ready = !r_hold_full || w_load;
  assign w_accept   = s_if.s_valid && s_if.s_ready;

  assign w_next_cnt = (r_bit_cnt == CNT_W'(FRAME - 1)) ? '0 : r_bit_cnt + 1'b1;
  assign w_next_lr  = (w_next_cnt >= CNT_W'(SLOT_W));
  assign w_k        = w_next_lr ? (w_next_cnt - CNT_W'(SLOT_W)) : w_next_cnt;

  // Underrun source: either the previous pair again, or silence when muting.
`ifdef UNDERRUN_MUTE_EN
  assign w_load_l = r_hold_full ? r_hold_l : '0;
  assign w_load_r = r_hold_full ? r_hold_r : '0;
`else
  assign w_load_l = r_hold_full ? r_hold_l : r_last_l;
  assign w_load_r = r_hold_full ? r_hold_r : r_last_r;
`endif

  // The bit launched on a load edge must come from the pair being loaded, not the old one.
  assign w_nxt_l = w_load ? w_load_l : r_sh_l;
  assign w_nxt_r = w_load ? w_load_r : r_sh_r;
  assign w_chan  = w_next_lr ? w_nxt_r : w_nxt_l;
  assign w_idx   = IDX_W'(SAMPLE_W - 1 - int'(w_k));
  assign w_bit   = (w_k < CNT_W'(SAMPLE_W)) ? w_chan[w_idx] : 1'b0;

  always_ff @(posedge CLOCK_50_B5B or negedge CPU_RESET_n) begin
    if (!CPU_RESET_n) begin
      r_xcnt         <= '0;
      r_xck          <= 1'b0;
      r_bcnt         <= '0;
      r_bclk         <= 1'b0;
      r_bit_cnt      <= CNT_W'(FRAME - 1);
      r_lrck         <= 1'b0;
      r_dat          <= 1'b0;
      r_strobe       <= 1'b0;
      r_underrun_cnt <= '0;
      r_hold_full    <= 1'b0;
      r_hold_l       <= '0;
      r_hold_r       <= '0;
      r_last_l       <= '0;
      r_last_r       <= '0;
      r_sh_l         <= '0;
      r_sh_r         <= '0;
    end else begin
      r_xcnt   <= w_xwrap ? '0 : r_xcnt + 1'b1;
      r_bcnt   <= w_bwrap ? '0 : r_bcnt + 1'b1;
      r_strobe <= w_load;
      if (w_xwrap) r_xck <= ~r_xck;
      if (w_bwrap) r_bclk <= ~r_bclk;
      if (w_fall) begin
        r_bit_cnt <= w_next_cnt;
        r_lrck    <= w_next_lr;
        r_dat     <= w_bit;
      end
      if (w_load) begin
        r_sh_l   <= w_load_l;
        r_sh_r   <= w_load_r;
        r_last_l <= w_load_l;
        r_last_r <= w_load_r;
        if (!r_hold_full && r_underrun_cnt != 16'hFFFF)
          r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
      if (w_accept) begin
        r_hold_l    <= s_if.s_left;
        r_hold_r    <= s_if.s_right;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  assign AUD_XCK      = r_xck;
  assign AUD_BCLK     = r_bclk;
  assign AUD_DACLRCK  = r_lrck;
  assign AUD_DACDAT   = r_dat;
  assign frame_strobe = r_strobe;
  assign underrun_cnt = r_underrun_cnt;
endmodule

// File: tb/tb_aud_dac_serializer.sv
// tb/tb_aud_dac_serializer.sv - scoreboard bench for aud_dac_serializer
module tb_aud_dac_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic xck, bclk, lrck, dat, strobe;
  logic [15:0] ucnt;

  aud_dac_serializer_if #(.SAMPLE_W(24)) sif ();

  aud_dac_serializer #(.SAMPLE_W(24), .SLOT_W(32), .MCLK_HALF(2), .BCLK_HALF(4)) dut (
    .CLOCK_50_B5B (clk),
    .CPU_RESET_n  (rst_n),
    .s_if         (sif.slave),
    .AUD_XCK      (xck),
    .AUD_BCLK     (bclk),
    .AUD_DACLRCK  (lrck),
    .AUD_DACDAT   (dat),
    .frame_strobe (strobe),
    .underrun_cnt (ucnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          c;
  } pair_t;

  pair_t       q[$];
  logic [23:0] last_l = '0, last_r = '0;
  int          mcnt = 0;
  int          total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic model_reset();
    q.delete();
    last_l = '0;
    last_r = '0;
    mcnt   = 0;
  endtask

  // Left-justified frame: 24 data bits MSB first then 8 zeros, left slot before right.
  function automatic logic [63:0] frame_bits(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] fb;
    logic [23:0] ch, tmp;
    int k;
    fb = '0;
    for (int b = 0; b < 64; b++) begin
      ch  = (b >= 32) ? r : l;
      k   = b % 32;
      tmp = ch >> (23 - k);
      fb  = {fb[62:0], (k < 24) ? tmp[0] : 1'b0};
    end
    return fb;
  endfunction

  // Monitor: decides the expected pair at each frame load and captures it at BCLK rises.
  initial begin
    logic [23:0] el, er;
    logic [63:0] got_d, got_lr;
    pair_t       p;
    bit          ok;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && strobe) begin
        if (q.size() > 0 && q[0].c + 1 < cyc) begin
          p = q.pop_front();
          el = p.l;
          er = p.r;
          last_l = p.l;
          last_r = p.r;
        end else begin
`ifdef UNDERRUN_MUTE_EN
          last_l = '0;
          last_r = '0;
`endif
          el = last_l;
          er = last_r;
          if (mcnt < 65535) mcnt++;
        end
        chk("underrun_cnt", 64'(ucnt), 64'(mcnt));
        ok = 1'b1;
        got_d = '0;
        got_lr = '0;
        for (int b = 0; b < 64; b++) begin
          @(posedge bclk or negedge rst_n);
          if (!rst_n) begin
            ok = 1'b0;
            break;
          end
          got_d  = {got_d[62:0], dat};
          got_lr = {got_lr[62:0], lrck};
        end
        if (ok) begin
          chk("frame_data", got_d, frame_bits(el, er));
          chk("frame_lrck", got_lr, {32'h0, 32'hFFFF_FFFF});
        end
      end
    end
  end

  task automatic cycle(input logic v, input logic [23:0] l, input logic [23:0] r,
                       output logic acc, output logic rdy);
    @(negedge clk);
    sif.s_valid = v;
    sif.s_left  = v ? l : 24'($urandom);
    sif.s_right = v ? r : 24'($urandom);
    #1;
    rdy = sif.s_ready;
    acc = v && rdy && rst_n;
    if (acc) q.push_back('{l: l, r: r, c: cyc});
  endtask

  task automatic idle(input int n);
    logic a, rd;
    for (int i = 0; i < n; i++) cycle(1'b0, 24'h0, 24'h0, a, rd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_strobe(input string name);
    logic a, rd;
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b0, 24'h0, 24'h0, a, rd);
      if (strobe) return;
    end
    timeout(name);
  endtask

  initial begin
    logic a, rd, rdy_prev, prev_b;
    logic [23:0] cl, cr;
    int e_x, e_b, e_lr, e_d, j, n, acc_cnt, strobes, falls;

    sif.s_valid = 1'b0;
    sif.s_left  = '0;
    sif.s_right = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", 64'({xck, bclk, lrck, dat, strobe, sif.s_ready, ucnt}), 64'({5'b0, 1'b1, 16'h0}));
    @(negedge clk);
    rst_n = 1'b1;

    // Idle run: divider waveforms follow the cycle count since reset release
    e_x = 0; e_b = 0; e_lr = 0; e_d = 0;
    for (n = 1; n <= 1000; n++) begin
      cycle(1'b0, 24'h0, 24'h0, a, rd);
      j = n / 8;
      if (xck !== 1'((n / 2) % 2)) e_x++;
      if (bclk !== 1'((n / 4) % 2)) e_b++;
      if (lrck !== ((j == 0) ? 1'b0 : 1'(((j - 1) % 64) >= 32))) e_lr++;
      if (dat !== 1'b0) e_d++;
    end
    chk("xck_wave_errors", 64'(e_x), 64'd0);
    chk("bclk_wave_errors", 64'(e_b), 64'd0);
    chk("lrck_wave_errors", 64'(e_lr), 64'd0);
    chk("idle_dat_errors", 64'(e_d), 64'd0);

    // Pair offered before the first load, then a few underrun frames
    do_reset();
    cycle(1'b1, 24'h800001, 24'h7FFFFE, a, rd);
    chk("first_pair_accepted", 64'(a), 64'd1);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 24'h0, 24'h0, a, rd);
      if (strobe) strobes++;
    end
    chk("strobe_count_first", 64'(strobes), 64'd1);
    idle(1100);

    // Continuous supply: one transfer per frame, ready while loading a full holding reg
    cl = 24'($urandom);
    cr = 24'($urandom);
    acc_cnt = 0;
    strobes = 0;
    rdy_prev = 1'b0;
    for (int i = 0; i < 3200; i++) begin
      cycle(1'b1, cl, cr, a, rd);
      if (strobe) begin
        if (strobes > 0) begin
          chk("accepts_per_frame", 64'(acc_cnt), 64'd1);
          chk("ready_on_load", 64'(rdy_prev), 64'd1);
        end
        strobes++;
        acc_cnt = 0;
      end
      if (a) begin
        acc_cnt++;
        cl = 24'($urandom);
        cr = 24'($urandom);
      end
      rdy_prev = rd;
    end
    sif.s_valid = 1'b0;
    idle(1100);

    // Supply stops after one pair: following frames repeat it (or mute)
    do_reset();
    cycle(1'b1, 24'h123456, 24'h123456, a, rd);
    idle(1600);

    // Reset in the middle of the right slot
    wait_strobe("strobe_before_mid_reset");
    falls = 0;
    prev_b = bclk;
    for (int i = 0; i < 1000 && falls < 40; i++) begin
      cycle(1'b0, 24'h0, 24'h0, a, rd);
      if (prev_b && !bclk) falls++;
      prev_b = bclk;
    end
    chk("lrck_at_bit40", 64'(lrck), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 64'({xck, bclk, lrck, dat, strobe, sif.s_ready, ucnt}), 64'({5'b0, 1'b1, 16'h0}));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    prev_b = bclk;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 24'h0, 24'h0, a, rd);
      n++;
      if (prev_b && !bclk) break;
      prev_b = bclk;
    end
    chk("first_fall_after_reset", 64'(n), 64'd8);
    chk("load_on_first_fall", 64'(strobe), 64'd1);
    chk("lrck_after_first_fall", 64'(lrck), 64'd0);

    // Saturation of the underrun counter
    wait_strobe("strobe_before_preload");
    idle(1);
    force dut.r_underrun_cnt = 16'hFFFE;
    #1;
    release dut.r_underrun_cnt;
    mcnt = 65534;
    idle(1700);
    chk("underrun_saturated", 64'(ucnt), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aud_dac_serializer.md
Name: aud_dac_serializer

Overview:
- Downstream stage of the two-voice tone generator: accepts mixed 24-bit stereo samples over a valid/ready handshake.
- Generates the codec clocks AUD_XCK, AUD_BCLK and AUD_DACLRCK, and serialises the samples onto AUD_DACDAT in left-justified format, MSB first.
- Holds one sample pair in a skid register and reports underruns.
- Replaces the free-running inline serializer and its ripple-clocked dividers with a single-clock-domain block.

Parameters:
- SAMPLE_W, 24, sample width per channel in bits; must be ≤ SLOT_W.
- SLOT_W, 32, BCLK periods per channel slot; frame = 2*SLOT_W BCLK periods.
- MCLK_HALF, 2, system clocks per AUD_XCK half-period (50 MHz -> 12.5 MHz).
- BCLK_HALF, 4, system clocks per AUD_BCLK half-period (50 MHz -> 6.25 MHz, 97.66 kHz frame).

Ports:
- CLOCK_50_B5B  in  1  system clock, the only clock.
- CPU_RESET_n  in  1  reset, asynchronous and active-low.
- s_valid  in  1  sample pair offered.
- s_ready  out  1  block can accept a pair this cycle.
- s_left  in  SAMPLE_W  left sample, two's complement.
- s_right  in  SAMPLE_W  right sample, two's complement.
- AUD_XCK  out  1  codec master clock.
- AUD_BCLK  out  1  bit clock.
- AUD_DACLRCK  out  1  0 = left slot, 1 = right slot.
- AUD_DACDAT  out  1  serial data.
- frame_strobe  out  1  one-cycle pulse when a frame is loaded.
- underrun_cnt  out  16  saturating count of frames loaded without a fresh pair.

Behaviour:
- Reset values:
  - AUD_XCK, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_strobe all 0; s_ready = 1; underrun_cnt = 0.
  - Holding register empty; last-pair register = 0.
  - bit_cnt = 2*SLOT_W-1; both divider counters = 0.
- Reset mid-operation aborts the frame immediately. Outputs return to reset values asynchronously; no partial-frame completion.
- XCK divider: counter 0..MCLK_HALF-1; AUD_XCK toggles on the cycle the counter wraps.
- BCLK divider: counter 0..BCLK_HALF-1, independent of the XCK divider. AUD_BCLK toggles on wrap.
  - fall_evt = wrap while AUD_BCLK = 1 (registered output goes 1->0 next edge).
  - AUD_BCLK first rises BCLK_HALF cycles after reset release and first falls 2*BCLK_HALF cycles after.
- At each fall_evt:
  - bit_cnt <= (bit_cnt == 2*SLOT_W-1) ? 0 : bit_cnt+1.
  - AUD_DACLRCK and AUD_DACDAT update on the same edge as AUD_BCLK falls, so data is stable at the codec's rising-edge sample point.
- AUD_DACLRCK = 1 when the new bit_cnt ≥ SLOT_W, else 0.
- Frame load (fall_evt with bit_cnt wrapping to 0):
  - If the holding register is full: shift pair <= holding pair; last-pair <= holding pair; holding becomes empty.
  - If it is empty: shift pair <= last-pair (repeat); underrun_cnt increments, saturating at 0xFFFF.
  - frame_strobe = 1 for exactly the cycle after the load edge.
- Slot data: slot bit index k = bit_cnt mod SLOT_W.
  - For k < SAMPLE_W, AUD_DACDAT = channel bit (SAMPLE_W-1-k).
  - For k ≥ SAMPLE_W, AUD_DACDAT = 0.
  - Left channel while LRCK = 0, right channel while LRCK = 1. The MSB appears on the same falling edge as the LRCK transition.
- Handshake:
  - s_ready = !hold_full || load_now (combinational, load_now = frame-load condition this cycle).
  - Transfer when s_valid && s_ready; the pair is captured next edge.
  - Simultaneous load and accept: the loaded pair is the old holding content; the new pair occupies holding, which stays full.
  - s_left and s_right are ignored when s_valid = 0.
- Latency: an accepted pair begins on AUD_DACDAT at the next frame-load edge, at most 2*SLOT_W*2*BCLK_HALF system cycles later.
- Parameter legality: SAMPLE_W > SLOT_W, or any *_HALF < 1, is a static error (elaboration-time check).

Optional Feature:
- UNDERRUN_MUTE_EN
- Defined: on an underrun frame load, the shift pair and last-pair are loaded with 0 (silence); underrun_cnt still counts.
- Undefined: the last pair repeats, as described above.

Test Plan:
- Reset, no s_valid, 1000 cycles -> AUD_XCK period 4 cycles, AUD_BCLK period 8 cycles, AUD_DACLRCK period 512 cycles, AUD_DACDAT = 0, underrun_cnt increments once per frame starting at 1.
- Pair L = 0x800001, R = 0x7FFFFE presented before the first frame load -> left slot bits 1,0..0,1 then eight 0s; right slot 0,1..1,0 then eight 0s; underrun_cnt = 0; frame_strobe pulses once.
- s_valid held high continuously with incrementing pairs -> exactly one transfer per frame (512 cycles), no pair lost or duplicated, s_ready high on the load cycle while holding is full.
- Stop supplying after pair L = R = 0x123456 -> next frame repeats 0x123456 and underrun_cnt = 1; with UNDERRUN_MUTE_EN, that frame outputs all zeros instead.
- Assert CPU_RESET_n low mid right slot (bit_cnt = 40) -> all outputs 0 within the same cycle and s_ready = 1; after release the first AUD_BCLK fall occurs 8 cycles later with bit_cnt = 0.
- Force 65540 underruns (via backdoor preload of underrun_cnt to 0xFFFE) -> counter stops at 0xFFFF.
